// File: rtl/sorter_job_arbiter.sv
// Round-robin arbiter sharing one Sorter between two requesters: clears the sorter,
// streams ELEMENT_NUM words from the owner, routes sorted writes back, and releases.
module sorter_job_arbiter #(
  parameter int DATA_WIDTH       = 32,
  parameter int ELEMENT_NUM      = 16,
  parameter int LOG2_ELEMENT_NUM = 4,
  parameter int TIMEOUT          = 4096
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0,
  input  logic                        req1,
  input  logic                        src_valid0,
  input  logic                        src_valid1,
  input  logic [DATA_WIDTH-1:0]       src_data0,
  input  logic [DATA_WIDTH-1:0]       src_data1,
  output logic                        gnt0,
  output logic                        gnt1,
  output logic                        sorter_clr,
  output logic                        UM_valid,
  output logic [DATA_WIDTH-1:0]       UM_data,
  input  logic                        SM_valid,
  input  logic [LOG2_ELEMENT_NUM-1:0] SM_addr,
  input  logic [DATA_WIDTH-1:0]       SM_data,
  input  logic                        done,
  output logic                        dst_valid0,
  output logic                        dst_valid1,
  output logic [LOG2_ELEMENT_NUM-1:0] dst_addr,
  output logic [DATA_WIDTH-1:0]       dst_data,
  output logic                        job_done0,
  output logic                        job_done1,
  output logic                        job_err
);

  localparam int CNT_W = LOG2_ELEMENT_NUM + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_WAIT,
    S_RELEASE
  } state_t;

  state_t                        state_q, state_d;
  logic                          rr_q, rr_d;
  logic                          owner_q, owner_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [TMO_W-1:0]              tmo_q, tmo_d;
  logic [1:0]                    gnt_q, gnt_d;
  logic                          clr_q, clr_d;
  logic                          um_valid_q, um_valid_d;
  logic [DATA_WIDTH-1:0]         um_data_q, um_data_d;
  logic [1:0]                    dst_valid_q, dst_valid_d;
  logic [LOG2_ELEMENT_NUM-1:0]   dst_addr_q, dst_addr_d;
  logic [DATA_WIDTH-1:0]         dst_data_q, dst_data_d;
  logic [1:0]                    job_done_q, job_done_d;
  logic                          job_err_q, job_err_d;

  logic                          own_valid;
  logic [DATA_WIDTH-1:0]         own_data;

  assign own_valid = owner_q ? src_valid1 : src_valid0;
  assign own_data  = owner_q ? src_data1  : src_data0;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    gnt_d       = gnt_q;
    clr_d       = 1'b0;
    um_valid_d  = 1'b0;
    um_data_d   = um_data_q;
    dst_valid_d = '0;
    dst_addr_d  = dst_addr_q;
    dst_data_d  = dst_data_q;
    job_done_d  = '0;
    job_err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          owner_d = (req0 && req1) ? rr_q : req1;
          gnt_d   = owner_d ? 2'b10 : 2'b01;
          clr_d   = 1'b1;
          state_d = S_CLEAR;
        end
      end

      S_CLEAR: begin
        cnt_d   = '0;
        state_d = S_LOAD;
      end

      S_LOAD: begin
        if (own_valid) begin
          um_valid_d = 1'b1;
          um_data_d  = own_data;
          cnt_d      = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ELEMENT_NUM - 1)) begin
            tmo_d   = '0;
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // A write coinciding with done (or with the abort) is still forwarded.
        if (SM_valid) begin
          dst_valid_d[owner_q] = 1'b1;
          dst_addr_d           = SM_addr;
          dst_data_d           = SM_data;
        end
        if (done) begin
          job_done_d[owner_q] = 1'b1;
          rr_d                = ~owner_q;
          state_d             = S_RELEASE;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          job_err_d = 1'b1;
          gnt_d     = '0;
          rr_d      = ~owner_q;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      S_RELEASE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_q        <= 1'b0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      gnt_q       <= '0;
      clr_q       <= 1'b0;
      um_valid_q  <= 1'b0;
      um_data_q   <= '0;
      dst_valid_q <= '0;
      dst_addr_q  <= '0;
      dst_data_q  <= '0;
      job_done_q  <= '0;
      job_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      gnt_q       <= gnt_d;
      clr_q       <= clr_d;
      um_valid_q  <= um_valid_d;
      um_data_q   <= um_data_d;
      dst_valid_q <= dst_valid_d;
      dst_addr_q  <= dst_addr_d;
      dst_data_q  <= dst_data_d;
      job_done_q  <= job_done_d;
      job_err_q   <= job_err_d;
    end
  end

  assign gnt0       = gnt_q[0];
  assign gnt1       = gnt_q[1];
  assign sorter_clr = clr_q;
  assign UM_valid   = um_valid_q;
  assign UM_data    = um_data_q;
  assign dst_valid0 = dst_valid_q[0];
  assign dst_valid1 = dst_valid_q[1];
  assign dst_addr   = dst_addr_q;
  assign dst_data   = dst_data_q;
  assign job_done0  = job_done_q[0];
  assign job_done1  = job_done_q[1];
  assign job_err    = job_err_q;

endmodule
